// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional two-stop-bit support is enabled by defining UART_TX_TWO_STOP_EN.
package uart_pkg;

    // Frame sequencer states; STOP_2 only exists with the two-stop option.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
        ST_STOP   = 3'd4,
        ST_STOP_2 = 3'd5
`else
        ST_STOP   = 3'd4
`endif
    } uart_state_t;

    // Output-mux select codes.
    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    // Parity of a byte-sized word; odd type inverts even parity.
    function automatic logic parity8(input logic [7:0] w, input logic odd);
        return (^w) ^ odd;
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator for the UART transmitter.
// Even parity when i_par_typ=0, odd parity when i_par_typ=1.
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_par_bit
);

    logic w_xor;

    // Reduction XOR gives even parity; the type bit flips it to odd.
    always_comb begin
        w_xor     = ^i_data;
        o_par_bit = w_xor ^ i_par_typ;
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start / data LSB-first / parity / stop.
// Define UART_TX_TWO_STOP_EN to add the STOP2 port and second stop bit.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  STOP2,
`endif
    output logic [1:0]            MUX_SEL,
    output logic                  SER_DATA,
    output logic                  PAR_BIT,
    output logic                  BUSY
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    uart_state_t           r_state;
    uart_state_t           w_next;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  w_accept;
    logic                  w_par;
`ifdef UART_TX_TWO_STOP_EN
    logic                  r_stop2;
`endif

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_par (
        .i_data    (P_DATA),
        .i_par_typ (PAR_TYP),
        .o_par_bit (w_par)
    );

    // State register; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, mux-select decode and word acceptance.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        MUX_SEL  = SEL_STOP;
        BUSY     = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    w_accept = 1'b1;
                    w_next   = ST_START;
                end
            end
            ST_START: begin
                MUX_SEL = SEL_START;
                w_next  = ST_DATA;
            end
            ST_DATA: begin
                MUX_SEL = SEL_DATA;
                if (r_cnt == LAST) begin
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                MUX_SEL = SEL_PAR;
                w_next  = ST_STOP;
            end
            ST_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                if (r_stop2) begin
                    w_next = ST_STOP_2;
                end else if (DATA_VALID) begin
                    w_accept = 1'b1;
                    w_next   = ST_START;
                end else begin
                    w_next = ST_IDLE;
                end
`else
                if (DATA_VALID) begin
                    w_accept = 1'b1;
                    w_next   = ST_START;
                end else begin
                    w_next = ST_IDLE;
                end
`endif
            end
`ifdef UART_TX_TWO_STOP_EN
            ST_STOP_2: begin
                if (DATA_VALID) begin
                    w_accept = 1'b1;
                    w_next   = ST_START;
                end else begin
                    w_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Word/config latch on acceptance, then shift out LSB first.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shreg   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_shreg   <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_bit <= w_par;
        end else if (r_state == ST_DATA) begin
            r_shreg <= r_shreg >> 1;
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    // Stop-bit count is fixed for the frame at acceptance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stop2 <= 1'b0;
        end else if (w_accept) begin
            r_stop2 <= STOP2;
        end
    end
`endif

    // Bit counter: cleared in START, saturates at the last data bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (r_state == ST_START) begin
            r_cnt <= '0;
        end else if (r_state == ST_DATA && r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign SER_DATA = r_shreg[0];
    assign PAR_BIT  = r_par_bit;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: stimulus queues per-cycle frame
// expectations, a negedge monitor pops and compares while BUSY is high.
module tb_uart_tx_fsm;
    import uart_pkg::*;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
`ifdef UART_TX_TWO_STOP_EN
    logic       STOP2;
`endif
    logic [1:0] MUX_SEL;
    logic       SER_DATA;
    logic       PAR_BIT;
    logic       BUSY;

    typedef struct {
        logic [1:0] sel;
        bit         chk_ser;
        logic       ser;
        bit         chk_par;
        logic       par;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
`ifdef UART_TX_TWO_STOP_EN
        .STOP2      (STOP2),
`endif
        .MUX_SEL    (MUX_SEL),
        .SER_DATA   (SER_DATA),
        .PAR_BIT    (PAR_BIT),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] d, input bit pe,
                                       input logic par, input int nstop);
        exp_t e;
        e = '{sel: SEL_START, chk_ser: 0, ser: 0, chk_par: 0, par: 0};
        sb.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e = '{sel: SEL_DATA, chk_ser: 1, ser: d[i], chk_par: 0, par: 0};
            sb.push_back(e);
        end
        if (pe) begin
            e = '{sel: SEL_PAR, chk_ser: 0, ser: 0, chk_par: 1, par: par};
            sb.push_back(e);
        end
        for (int i = 0; i < nstop; i++) begin
            e = '{sel: SEL_STOP, chk_ser: 0, ser: 0, chk_par: 0, par: 0};
            sb.push_back(e);
        end
    endfunction

    // Monitor: one expected record per busy cycle.
    always @(negedge CLK) begin
        if (RST === 1'b1 && BUSY === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL extra_busy: got sel=%b with nothing expected",
                         MUX_SEL);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (MUX_SEL !== e.sel ||
                    (e.chk_ser && SER_DATA !== e.ser) ||
                    (e.chk_par && PAR_BIT !== e.par)) begin
                    n_bad++;
                    $display("FAIL frame_bit: got sel=%b ser=%b par=%b expected sel=%b ser=%b par=%b",
                             MUX_SEL, SER_DATA, PAR_BIT, e.sel, e.ser, e.par);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] d, input bit pe, input bit pt,
                         input bit st2);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        STOP2      = st2;
`else
        if (st2) $display("note: two-stop request ignored in this build");
`endif
    endtask

    task automatic send(input logic [7:0] d, input bit pe, input bit pt,
                        input bit st2, input logic par, input int nstop);
        @(posedge CLK);
        #1;
        drive(d, pe, pt, st2);
        push_frame(d, pe, par, nstop);
        @(posedge CLK);
        #1;
        DATA_VALID = 1'b0;
    endtask

    task automatic send_in_stop(input logic [7:0] d, input bit pe,
                                input bit pt, input logic par);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge CLK);
            #1;
            if (BUSY === 1'b1 && MUX_SEL === SEL_STOP) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL stop_wait: got no STOP cycle expected one within 40");
        end
        drive(d, pe, pt, 1'b0);
        push_frame(d, pe, par, 1);
        @(posedge CLK);
        #1;
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int exp_len);
        int n    = 0;
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLK);
            if (BUSY === 1'b1) n++;
            else done = 1;
        end
        chk("idle_reached", 32'(done), 32'd1);
        chk("busy_len", 32'(n), 32'(exp_len));
        chk("idle_sel", 32'(MUX_SEL), 32'(SEL_STOP));
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        STOP2      = 1'b0;
`endif
        #3;
        chk("rst_sel", 32'(MUX_SEL), 32'(SEL_STOP));
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ser", 32'(SER_DATA), 32'd0);
        chk("rst_par", 32'(PAR_BIT), 32'd0);
        #20;
        @(negedge CLK);
        RST = 1'b1;

        // A5 without parity: 10 busy cycles.
        send(8'hA5, 0, 0, 0, 1'b0, 1);
        wait_idle(10);

        // A5 even parity -> 0, odd parity -> 1; 11 busy cycles.
        send(8'hA5, 1, 0, 0, 1'b0, 1);
        wait_idle(11);
        send(8'hA5, 1, 1, 0, 1'b1, 1);
        wait_idle(11);

        // Back-to-back 3C then FF (odd parity -> 1).
        send(8'h3C, 0, 0, 0, 1'b0, 1);
        send_in_stop(8'hFF, 1, 1, 1'b1);
        @(negedge CLK);
        chk("b2b_busy", 32'(BUSY), 32'd1);
        chk("b2b_start", 32'(MUX_SEL), 32'(SEL_START));
        wait_idle(10);

        // C3 even parity; a 00 request and config change mid-frame are ignored.
        send(8'hC3, 1, 0, 0, 1'b0, 1);
        repeat (3) @(posedge CLK);
        #1;
        drive(8'h00, 0, 1, 0);
        @(posedge CLK);
        #1;
        DATA_VALID = 1'b0;
        wait_idle(7);

        // Reset during data bit 3 aborts the frame.
        send(8'hA5, 0, 0, 0, 1'b0, 1);
        repeat (4) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("abort_sel", 32'(MUX_SEL), 32'(SEL_STOP));
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_ser", 32'(SER_DATA), 32'd0);
        sb.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        send(8'h81, 1, 1, 0, 1'b1, 1);
        wait_idle(11);

`ifdef UART_TX_TWO_STOP_EN
        // Two stop bits after parity: 12 busy cycles.
        send(8'h0F, 1, 0, 1, 1'b0, 2);
        wait_idle(12);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
